// File: rtl/input_conditioner.sv
// input_conditioner: synchronises, debounces and edge-detects raw buttons and slide switches.
module input_conditioner #(
  parameter int N_BTN           = 4,
  parameter int N_SLD           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] button_raw,
  input  logic [N_SLD-1:0] slide_raw,
  output logic [N_BTN-1:0] button,
  output logic [N_BTN-1:0] button_press,
  output logic [N_SLD-1:0] slide
);
  localparam int N = N_BTN + N_SLD;
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  logic [N-1:0] sync1, sync2, stable, stable_next;
  logic [CNT_WIDTH-1:0] cnt [N];
  logic [CNT_WIDTH-1:0] cnt_next [N];
  // Buttons and slides share one debounce array; buttons occupy the low bits.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      cnt_next[i] = (sync2[i] == stable[i] || cnt[i] == LAST) ? '0 : cnt[i] + CNT_WIDTH'(1);
      stable_next[i] = (sync2[i] != stable[i] && cnt[i] == LAST) ? sync2[i] : stable[i];
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
      stable <= '0;
      button_press <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      sync1 <= {slide_raw, button_raw};
      sync2 <= sync1;
      stable <= stable_next;
      button_press <= stable_next[N_BTN-1:0] & ~stable[N_BTN-1:0];
      for (int i = 0; i < N; i++) cnt[i] <= cnt_next[i];
    end
  end
  assign button = stable[N_BTN-1:0];
  assign slide = stable[N-1:N_BTN];
endmodule

// File: tb/tb_input_conditioner.sv
// tb_input_conditioner: directed and random checks against a sliding-window debounce model.
module tb_input_conditioner;
  localparam int D = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [3:0] button_raw = '0, slide_raw = '0;
  logic [3:0] button, button_press, slide;
  int checks = 0, failures = 0;
  bit done = 1'b0;

  input_conditioner #(.N_BTN(4), .N_SLD(4), .DEBOUNCE_CYCLES(D), .CNT_WIDTH(16)) dut (
    .clock(clock), .reset_n(reset_n), .button_raw(button_raw), .slide_raw(slide_raw),
    .button(button), .button_press(button_press), .slide(slide)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: raw is seen two edges late; a line flips once its last D delayed samples all differ from it.
  logic [7:0] d1 = '0, d2 = '0, m_out = '0;
  logic [3:0] m_press = '0;
  logic [7:0] win [$];
  always @(posedge clock) begin
    logic [7:0] nxt;
    if (!reset_n) begin
      d1 = '0; d2 = '0; m_out = '0; m_press = '0;
      win.delete();
    end else begin
      win.push_back(d2);
      if (win.size() > D) void'(win.pop_front());
      nxt = m_out;
      for (int i = 0; i < 8; i++) begin
        bit all_diff;
        all_diff = (win.size() == D);
        foreach (win[j]) if (win[j][i] == m_out[i]) all_diff = 1'b0;
        if (all_diff) nxt[i] = ~m_out[i];
      end
      m_press = nxt[3:0] & ~m_out[3:0];
      m_out = nxt;
      d2 = d1;
      d1 = {slide_raw, button_raw};
    end
  end

  always @(negedge clock) if (!done) begin
    chk("model_button", {4'h0, button}, {4'h0, m_out[3:0]});
    chk("model_slide", {4'h0, slide}, {4'h0, m_out[7:4]});
    chk("model_press", {4'h0, button_press}, {4'h0, m_press});
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  initial begin
    button_raw = 4'hF;
    step(3);
    chk("reset_button", {4'h0, button}, 8'h00);
    chk("reset_press", {4'h0, button_press}, 8'h00);
    chk("reset_slide", {4'h0, slide}, 8'h00);
    reset_n = 1'b1;
    step(5);
    chk("post_reset_hold_button", {4'h0, button}, 8'h00);
    step(1);
    chk("post_reset_button", {4'h0, button}, 8'h0F);
    chk("post_reset_press", {4'h0, button_press}, 8'h0F);
    step(1);
    chk("post_reset_press_clear", {4'h0, button_press}, 8'h00);
    button_raw[2] = 1'b0;
    step(5);
    chk("release_hold", {4'h0, button}, 8'h0F);
    step(1);
    chk("release_button", {4'h0, button}, 8'h0B);
    chk("release_no_press", {4'h0, button_press}, 8'h00);
    button_raw = '0;
    step(10);
    button_raw[0] = 1'b1;
    step(5);
    chk("press0_wait", {4'h0, button}, 8'h00);
    step(1);
    chk("press0_button", {4'h0, button}, 8'h01);
    chk("press0_pulse", {4'h0, button_press}, 8'h01);
    step(1);
    chk("press0_pulse_clear", {4'h0, button_press}, 8'h00);
    for (int k = 0; k < 10; k++) begin
      button_raw[1] = ~button_raw[1];
      step(2);
    end
    chk("glitch_rejected", {4'h0, button}, 8'h01);
    button_raw[1] = 1'b1;
    step(5);
    chk("glitch_then_hold_wait", {4'h0, button_press}, 8'h00);
    step(1);
    chk("glitch_then_hold_press", {4'h0, button_press}, 8'h02);
    button_raw = '0;
    step(10);
    button_raw = 4'b1001;
    slide_raw[2] = 1'b1;
    step(6);
    chk("multi_button", {4'h0, button}, 8'h09);
    chk("multi_press", {4'h0, button_press}, 8'h09);
    chk("multi_slide", {4'h0, slide}, 8'h04);
    step(1);
    chk("multi_press_clear", {4'h0, button_press}, 8'h00);
    slide_raw[1] = 1'b1;
    step(4);
    reset_n = 1'b0;
    step(1);
    chk("mid_count_reset_slide", {4'h0, slide}, 8'h00);
    chk("mid_count_reset_button", {4'h0, button}, 8'h00);
    reset_n = 1'b1;
    step(5);
    chk("reset_rearm_wait", {4'h0, slide}, 8'h00);
    step(1);
    chk("reset_rearm_slide", {4'h0, slide}, 8'h06);
    chk("reset_rearm_press", {4'h0, button_press}, 8'h09);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) begin
        int b;
        b = $urandom_range(0, 7);
        if (b < 4) button_raw[b] = ~button_raw[b];
        else slide_raw[b-4] = ~slide_raw[b-4];
      end
      reset_n = ($urandom_range(0, 599) != 0);
      step(1);
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end
endmodule
